// File: rtl/ham_sequencer.sv
// Two-port arbitrated population counter: one 8-bit HAM block is time-shared
// across the four byte slices of a captured 32-bit operand.

module ham (
    input  logic [7:0] in_i,
    output logic [3:0] ones_o
);
    always_comb begin
        ones_o = '0;
        for (int i = 0; i < 8; i++) begin
            ones_o = ones_o + 4'(in_i[i]);
        end
    end
endmodule

module ham_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic        req1,
    input  logic [31:0] a1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic [5:0]  result,
    output logic        owner
);
    localparam int unsigned OP_W    = 32;
    localparam int unsigned SLICE_W = 8;
    localparam int unsigned ACC_W   = 6;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [OP_W-1:0]    shreg_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               own_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic [ACC_W-1:0]   result_q;
    logic               owner_q;

    logic               idle_c;
    logic               gnt0_c;
    logic               gnt1_c;
    logic [3:0]         slice_ones;
    logic [ACC_W-1:0]   acc_d;

    // Tie goes to the port that was not granted last; grants never overlap.
    assign idle_c = (state_q == IDLE) && !rst;
    assign gnt1_c = idle_c && req1 && (!req0 || !last_q);
    assign gnt0_c = idle_c && req0 && !gnt1_c;

    ham u_ham (
        .in_i   (shreg_q[SLICE_W-1:0]),
        .ones_o (slice_ones)
    );

    assign acc_d = acc_q + ACC_W'(slice_ones);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            own_q    <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            owner_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0_c || gnt1_c) begin
                        shreg_q <= gnt1_c ? a1 : a0;
                        own_q   <= gnt1_c;
                        last_q  <= gnt1_c;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q >> SLICE_W;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(3)) begin
                        result_q <= acc_d;
                        owner_q  <= own_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0   = gnt0_c;
    assign gnt1   = gnt1_c;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_ham_sequencer.sv
// Scoreboard bench for ham_sequencer: expected {result, owner} is queued at the
// grant and compared at the done pulse; fixed-latency and hold behaviour checked per cycle.

module tb_ham_sequencer;
    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] a0;
    logic        req1;
    logic [31:0] a1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic [5:0]  result;
    logic        owner;

    typedef struct packed {
        logic [5:0] res;
        logic       own;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_cmp;
    int   n_err;

    ham_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .req1   (req1),
        .a1     (a1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .busy   (busy),
        .done   (done),
        .result (result),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller has set req/operand at a negedge; checks the grant, then T+1..T+5.
    task automatic do_op(input logic port, input bit drop_req, input bit change_op,
                         input logic [31:0] new_op, input bit raise_other);
        logic [10:0] obs;
        logic [10:0] want;
        logic [1:0]  gwant;
        #1;
        gwant = port ? 2'b10 : 2'b01;
        n_cmp++;
        if ({gnt1, gnt0} !== gwant) begin
            n_err++;
            $display("FAIL grant_port%0d: gnt1,gnt0=%b required %b", port, {gnt1, gnt0}, gwant);
        end
        sb.push_back('{res: 6'($countones(port ? a1 : a0)), own: port});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (drop_req) begin
                    if (port) req1 = 1'b0; else req0 = 1'b0;
                end
                if (change_op) begin
                    if (port) a1 = new_op; else a0 = new_op;
                end
            end
            if (k == 2 && raise_other) begin
                if (port) req0 = 1'b1; else req1 = 1'b1;
            end
            #1;
            if (k == 5) begin
                if (sb.size() > 0) last_exp = sb.pop_front();
            end
            want = {1'b1, 1'(k == 5), 2'b00, last_exp.res, last_exp.own};
            obs  = {busy, done, gnt1, gnt0, result, owner};
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL op_cycle_T+%0d: busy,done,gnt1,gnt0,result,owner=%b required %b",
                         k, obs, want);
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        a0   = 32'hFFFF_FFFF;
        a1   = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({gnt1, gnt0, busy, done, result, owner} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_state: gnt1,gnt0,busy,done,result,owner=%b required 0",
                     {gnt1, gnt0, busy, done, result, owner});
        end
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        last_exp = '0;
    endtask

    task automatic test_single();
        @(negedge clk); req0 = 1'b1; a0 = 32'hFFFF_FFFF;
        do_op(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); req1 = 1'b1; a1 = 32'h0000_0000;
        do_op(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); req1 = 1'b1; a1 = 32'hA5A5_A5A5;
        do_op(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_operand_change();
        @(negedge clk); req0 = 1'b1; a0 = 32'h0101_0101;
        do_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_req_during_run();
        @(negedge clk); req0 = 1'b1; a0 = 32'h0000_00FF; a1 = 32'h0000_0007;
        do_op(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        do_op(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk); req0 = 1'b1; a0 = 32'hFFFF_0000;
        #1;
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_err++;
            $display("FAIL abort_grant: gnt1,gnt0=%b required 01", {gnt1, gnt0});
        end
        @(negedge clk); req0 = 1'b0;
        @(negedge clk); rst = 1'b1; req1 = 1'b1;
        #1;
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b00) begin
            n_err++;
            $display("FAIL gnt_in_reset_run: gnt1,gnt0=%b required 00", {gnt1, gnt0});
        end
        @(negedge clk); rst = 1'b0; req1 = 1'b0; req0 = 1'b1; a0 = 32'h0000_0003;
        sb.delete();
        last_exp = '0;
        #1;
        n_cmp++;
        if ({busy, done, result, owner} !== 9'b0) begin
            n_err++;
            $display("FAIL abort_cleared: busy,done,result,owner=%b required 0",
                     {busy, done, result, owner});
        end
        do_op(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_tie_alternation();
        @(negedge clk); rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; a0 = 32'h0000_000F; a1 = 32'h8000_0001;
        #1;
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b00) begin
            n_err++;
            $display("FAIL gnt_in_reset_idle: gnt1,gnt0=%b required 00", {gnt1, gnt0});
        end
        @(negedge clk); rst = 1'b0;
        last_exp = '0;
        do_op(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            do_op(1'(i % 2), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_operand_change();
        test_req_during_run();
        test_reset_abort();
        test_tie_alternation();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
